// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: register IDs, status encodings and the
// architectural run state used by the register file.
package y86_pkg;

    localparam logic [3:0] RRSP  = 4'd4;
    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_read_port.sv
// One decode-stage read port: register ID decode plus the writeback bypass mux.
module regfile_read_port
    import y86_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  logic [3:0]        src,
    input  logic [14:0][63:0] regs,
    input  logic              bypass_en,
    input  logic [3:0]        dst_e,
    input  logic [3:0]        dst_m,
    input  logic [63:0]       val_e,
    input  logic [63:0]       val_m,
    output logic [63:0]       val
);

    // The M result is checked last so it overrides E, matching the write priority.
    always_comb begin
        val = '0;
        if (src != RNONE) begin
            val = regs[src];
            if (BYPASS && bypass_en) begin
                if (src == dst_e) begin
                    val = val_e;
                end
                if (src == dst_m) begin
                    val = val_m;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// Y86-64 architectural register file at the writeback stage, with sticky
// machine status and a retired-instruction counter.
module regfile_wb
    import y86_pkg::*;
#(
    parameter logic [63:0] RSP_INIT = 64'h0,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  srcA_i,
    input  logic [3:0]  srcB_i,
    output logic [63:0] valA_o,
    output logic [63:0] valB_o,
    input  logic        wb_valid_i,
    input  logic [3:0]  dstE_i,
    input  logic [3:0]  dstM_i,
    input  logic [63:0] valE_i,
    input  logic [63:0] valM_i,
    input  logic [1:0]  stat_i,
    output logic [1:0]  stat_o,
    output logic        halted_o,
    output logic [63:0] retired_o
);

    rf_state_t         state_q;
    rf_state_t         state_d;
    logic              commit;
    logic              halt_evt;
    logic [1:0]        stat_q;
    logic [63:0]       retired_q;
    logic [14:0][63:0] reg_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // HALTED is absorbing; only reset leaves it.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN && wb_valid_i && stat_i != STAT_AOK) begin
            state_d = ST_HALTED;
        end
    end

    always_comb begin
        commit   = wb_valid_i && state_q == ST_RUN && stat_i == STAT_AOK;
        halt_evt = wb_valid_i && state_q == ST_RUN && stat_i != STAT_AOK;
        halted_o = (state_q == ST_HALTED);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_q <= STAT_AOK;
        end else if (halt_evt) begin
            stat_q <= stat_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retired_q <= '0;
        end else if (commit) begin
            retired_q <= retired_q + 64'd1;
        end
    end

    // The M write is issued second so it wins a dstE == dstM collision.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_q       <= '0;
            reg_q[RRSP] <= RSP_INIT;
        end else if (commit) begin
            if (dstE_i != RNONE) begin
                reg_q[dstE_i] <= valE_i;
            end
            if (dstM_i != RNONE) begin
                reg_q[dstM_i] <= valM_i;
            end
        end
    end

    assign stat_o    = stat_q;
    assign retired_o = retired_q;

    regfile_read_port #(.BYPASS(BYPASS)) u_port_a (
        .src       (srcA_i),
        .regs      (reg_q),
        .bypass_en (commit),
        .dst_e     (dstE_i),
        .dst_m     (dstM_i),
        .val_e     (valE_i),
        .val_m     (valM_i),
        .val       (valA_o)
    );

    regfile_read_port #(.BYPASS(BYPASS)) u_port_b (
        .src       (srcB_i),
        .regs      (reg_q),
        .bypass_en (commit),
        .dst_e     (dstE_i),
        .dst_m     (dstM_i),
        .val_e     (valE_i),
        .val_m     (valM_i),
        .val       (valB_o)
    );

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed literal scenarios followed by
// randomized writeback traffic compared against a behavioural model.
module tb_regfile_wb;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  srcA = 4'hF;
    logic [3:0]  srcB = 4'hF;
    logic [63:0] valA;
    logic [63:0] valB;
    logic        wb_valid = 1'b0;
    logic [3:0]  dstE = 4'hF;
    logic [3:0]  dstM = 4'hF;
    logic [63:0] valE = '0;
    logic [63:0] valM = '0;
    logic [1:0]  stat = 2'd0;
    logic [1:0]  stat_out;
    logic        halted;
    logic [63:0] retired;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_regs [15];
    logic        m_halted;
    logic [1:0]  m_stat;
    logic [63:0] m_retired;

    regfile_wb #(.RSP_INIT(64'h100), .BYPASS(1'b1)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .srcA_i     (srcA),
        .srcB_i     (srcB),
        .valA_o     (valA),
        .valB_o     (valB),
        .wb_valid_i (wb_valid),
        .dstE_i     (dstE),
        .dstM_i     (dstM),
        .valE_i     (valE),
        .valM_i     (valM),
        .stat_i     (stat),
        .stat_o     (stat_out),
        .halted_o   (halted),
        .retired_o  (retired)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_read(input logic [3:0] src);
        if (src == 4'hF) return 64'h0;
        if (!m_halted && wb_valid && stat == 2'd0) begin
            if (src == dstM) return valM;
            if (src == dstE) return valE;
        end
        return m_regs[src];
    endfunction

    // Architectural model: an array of registers, a halted flag and a counter.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) m_regs[i] = 64'h0;
            m_regs[4] = 64'h100;
            m_halted  = 1'b0;
            m_stat    = 2'd0;
            m_retired = 64'h0;
        end else if (!m_halted && wb_valid) begin
            if (stat == 2'd0) begin
                if (dstE != 4'hF) m_regs[dstE] = valE;
                if (dstM != 4'hF) m_regs[dstM] = valM;
                m_retired = m_retired + 64'd1;
            end else begin
                m_halted = 1'b1;
                m_stat   = stat;
            end
        end
    end

    always @(negedge clk) begin
        check_output("valA", valA, exp_read(srcA));
        check_output("valB", valB, exp_read(srcB));
        check_output("stat_o", {62'h0, stat_out}, {62'h0, m_stat});
        check_output("halted_o", {63'h0, halted}, {63'h0, m_halted});
        check_output("retired_o", retired, m_retired);
    end

    task automatic apply_stimulus(input logic v, input logic [3:0] de, input logic [63:0] ve,
                                  input logic [3:0] dm, input logic [63:0] vm, input logic [1:0] st,
                                  input logic [3:0] sa, input logic [3:0] sb);
        @(posedge clk);
        #1;
        wb_valid = v;
        dstE     = de;
        valE     = ve;
        dstM     = dm;
        valM     = vm;
        stat     = st;
        srcA     = sa;
        srcB     = sb;
    endtask

    initial begin
        #12 rst = 1'b0;

        apply_stimulus(1'b0, 4'hF, 64'h0, 4'hF, 64'h0, 2'd0, 4'd4, 4'd0);
        #1;
        check_output("lit_rst_rsp", valA, 64'h100);
        check_output("lit_rst_r0", valB, 64'h0);
        check_output("lit_rst_retired", retired, 64'h0);
        check_output("lit_rst_halted", {63'h0, halted}, 64'h0);
        srcA = 4'hF;
        #1;
        check_output("lit_rnone", valA, 64'h0);

        apply_stimulus(1'b1, 4'd3, 64'hA5, 4'hF, 64'h0, 2'd0, 4'd3, 4'd0);
        #1;
        check_output("lit_bypass_e", valA, 64'hA5);
        apply_stimulus(1'b0, 4'hF, 64'h0, 4'hF, 64'h0, 2'd0, 4'd3, 4'($urandom_range(0, 15)));
        #1;
        check_output("lit_stored_e", valA, 64'hA5);
        check_output("lit_retired1", retired, 64'd1);

        apply_stimulus(1'b1, 4'd4, 64'h108, 4'd4, 64'hDEAD, 2'd0, 4'd4, 4'd4);
        #1;
        check_output("lit_bypass_collide", valA, 64'hDEAD);
        apply_stimulus(1'b0, 4'hF, 64'h0, 4'hF, 64'h0, 2'd0, 4'd4, 4'd3);
        #1;
        check_output("lit_collide_stored", valA, 64'hDEAD);

        apply_stimulus(1'b1, 4'd1, 64'h55, 4'hF, 64'h0, 2'd2, 4'd1, 4'd1);
        #1;
        check_output("lit_adr_nobypass", valA, 64'h0);
        apply_stimulus(1'b1, 4'd1, 64'h77, 4'hF, 64'h0, 2'd0, 4'd1, 4'd1);
        #1;
        check_output("lit_halt_stat", {62'h0, stat_out}, 64'd2);
        check_output("lit_halt_flag", {63'h0, halted}, 64'd1);
        check_output("lit_halt_nobypass", valA, 64'h0);
        apply_stimulus(1'b0, 4'hF, 64'h0, 4'hF, 64'h0, 2'd0, 4'd1, 4'd4);
        #1;
        check_output("lit_halt_r1", valA, 64'h0);
        check_output("lit_halt_retired", retired, 64'd2);

        apply_stimulus(1'b0, 4'hF, 64'h0, 4'hF, 64'h0, 2'd0, 4'd4, 4'd3);
        #2 rst = 1'b1;
        #1;
        check_output("lit_arst_rsp", valA, 64'h100);
        check_output("lit_arst_r3", valB, 64'h0);
        check_output("lit_arst_halted", {63'h0, halted}, 64'h0);
        check_output("lit_arst_retired", retired, 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        apply_stimulus(1'b1, 4'd3, 64'h11, 4'hF, 64'h0, 2'd0, 4'd3, 4'd4);
        apply_stimulus(1'b0, 4'hF, 64'h0, 4'hF, 64'h0, 2'd0, 4'd3, 4'd4);
        #1;
        check_output("lit_resume_r3", valA, 64'h11);
        check_output("lit_resume_retired", retired, 64'd1);

        force dut.retired_q = 64'hFFFF_FFFF_FFFF_FFFF;
        m_retired = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.retired_q;
        apply_stimulus(1'b1, 4'hF, 64'h123, 4'hF, 64'h456, 2'd0, 4'd3, 4'd4);
        apply_stimulus(1'b0, 4'hF, 64'h0, 4'hF, 64'h0, 2'd0, 4'd3, 4'd4);
        #1;
        check_output("lit_wrap_retired", retired, 64'h0);
        check_output("lit_wrap_r3", valA, 64'h11);
        check_output("lit_wrap_rsp", valB, 64'h100);

        for (int i = 0; i < 600; i++) begin
            if (i % 80 == 79) begin
                @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end else begin
                apply_stimulus(($urandom % 4) != 0,
                               ($urandom % 3 == 0) ? 4'hF : 4'($urandom % 15),
                               {$urandom, $urandom},
                               ($urandom % 3 == 0) ? 4'hF : 4'($urandom % 15),
                               {$urandom, $urandom},
                               ($urandom % 50 == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                               4'($urandom % 16),
                               4'($urandom % 16));
            end
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Y86-64 architectural register file; the receiving end of the writeback stage.
- Accepts the writeback pair (valE -> dstE, valM -> dstM) once per cycle and serves the two decode-stage read ports (srcA/srcB).
- Tracks the sticky machine status: the first non-AOK status freezes architectural state until reset.
- Maintains a retired-instruction counter.

Parameters:
- RSP_INIT, 64'h0, reset value of %rsp (register 4).
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports; when 0 reads return stored contents only.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- srcA_i  input  4  read port A register ID; 4'hF = RNONE.
- srcB_i  input  4  read port B register ID; 4'hF = RNONE.
- valA_o  output  64  read data A.
- valB_o  output  64  read data B.
- wb_valid_i  input  1  writeback slot carries an instruction this cycle.
- dstE_i  input  4  destination for valE; 4'hF = none.
- dstM_i  input  4  destination for valM; 4'hF = none.
- valE_i  input  64  ALU result.
- valM_i  input  64  memory read result.
- stat_i  input  2  status of the writeback instruction: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- stat_o  output  2  latched machine status.
- halted_o  output  1  1 once the machine has left AOK.
- retired_o  output  64  count of committed instructions.

Behaviour:
- Storage: 15 x 64-bit registers, IDs 0..14. ID 15 is never stored.
- Reads are combinational, zero latency. srcX = 4'hF returns 64'h0.
- Commit condition, "commit": wb_valid_i & state==RUN & stat_i==AOK.
- On a commit clock edge:
  - If dstE != F, reg[dstE] <= valE_i.
  - If dstM != F, reg[dstM] <= valM_i.
- Write collision: if dstE == dstM != F, valM wins (popq %rsp semantics).
- Bypass (BYPASS=1): when commit is active, srcX==dstM gives valM_i; otherwise srcX==dstE gives valE_i; otherwise stored value. Same M-over-E priority as the write.
- Bypass when BYPASS=0: read returns the old value; the new value is visible from the next cycle.
- State machine, states RUN and HALTED:
  - RUN -> HALTED on an edge where wb_valid_i & stat_i != AOK. That edge latches stat_o <= stat_i and sets halted_o <= 1. No register write occurs for that instruction.
  - HALTED is absorbing until rst_i: all writes are ignored, stat_o is held, retired_o is frozen, and bypass is disabled (reads return stored values).
  - wb_valid_i=0 produces no write, no state change and no count.
- retired_o increments by 1 on every commit edge, including commits with dstE=dstM=F (nop, jXX). It wraps 2^64-1 -> 0.
- Reset (async assert, released synchronously by the environment):
  - All registers 0, except reg[4] = RSP_INIT.
  - State RUN; stat_o = 0 (AOK); halted_o = 0; retired_o = 0.
  - Reset mid-operation discards any in-flight write that edge. valA_o/valB_o reflect the reset contents immediately.
- X-safety: dst/src IDs are only decoded when wb_valid_i=1 (writes) or always (reads); no latches inferred.

Decomposition:
- Shared package y86_pkg holds:
  - register IDs RRSP=4, RNONE=4'hF;
  - stat encodings STAT_AOK/HLT/ADR/INS;
  - the 2-bit stat typedef.
  - stat_module continues to produce stat_i upstream.
- One natural sub-module, regfile_read_port (ID decode + bypass mux), instantiated twice for A and B.
- State machine, counter and storage stay in regfile_wb.

Test Plan:
- Reset with RSP_INIT=64'h100 -> srcA=4 reads 64'h100; srcB=0 reads 0; srcA=F reads 0; stat_o=0, halted_o=0, retired_o=0.
- Commit dstE=3 valE=64'hA5, dstM=F -> same cycle with BYPASS=1, srcA=3 reads 64'hA5; next cycle reads 64'hA5 with any srcB drive; retired_o=1.
- Commit dstE=4 valE=64'h108, dstM=4 valM=64'hDEAD -> reg4=64'hDEAD; the bypass during that cycle also returns 64'hDEAD.
- wb_valid=1 stat_i=2 (ADR) with dstE=1 valE=64'h55 -> reg1 unchanged; stat_o=2 and halted_o=1 next cycle. Subsequent AOK commits to reg1 ignored; retired_o frozen.
- Assert rst_i asynchronously mid-cycle in HALTED after writes -> outputs return to reset values without a clock edge; normal commits resume after release.
- Force the retired counter to 64'hFFFF_FFFF_FFFF_FFFF, then issue a commit with dstE=dstM=F -> retired_o=0 and no register changes.
